lemon_exec_unit: RTL and testbench

- Combined execute/data-memory block for the single-cycle LemonPC RV64 core.
- Contains three parts:
  - a parameterised combinational ALU;
  - a control slice that detects EBREAK and holds the core halted;
  - a unified 64-bit-word memory with combinational read and synchronous byte-masked write.
- Sits beside the PC/register-file datapath. The memory serves both instruction fetch and data.

---
 rtl/lemon_exec_unit.sv | 147 ++++++++++++++
 tb/tb_lemon_exec_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lemon_exec_unit.sv
// -----------------------------------------------------------------------------
// lemon_exec_unit
//
// Execute / data-memory block for the single-cycle LemonPC RV64 core.
//   * Combinational ALU (add/sub/logic/shifts/set-less-than).
//   * Control slice: latches "halted" when EBREAK is executed; sticky until rst.
//   * Unified 64-bit-word memory: combinational little-endian read,
//     synchronous byte-masked write, blocked once the core is halted.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset (clears halt only)
//   inst       in   current instruction (EBREAK detection)
//   alu_a/b    in   ALU operands
//   alu_sel    in   ALU operation select
//   alu_res    out  ALU result (combinational)
//   mem_addr   in   byte address (bits [2:0] ignored for indexing)
//   mem_wdata  in   write data
//   mem_wen    in   write enable
//   mem_wmask  in   byte-lane write mask, bit i -> wdata[8i+7:8i]
//   mem_rdata  out  read data (combinational, 0 when out of range)
//   halt       out  high once EBREAK has been executed
// -----------------------------------------------------------------------------
module lemon_exec_unit #(
    parameter int          WIDTH     = 64,
    parameter int          MEM_WORDS = 4096,
    parameter logic [63:0] MEM_BASE  = 64'h0000_0000_8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] alu_res,
    input  logic [63:0]      mem_addr,
    input  logic [63:0]      mem_wdata,
    input  logic             mem_wen,
    input  logic [7:0]       mem_wmask,
    output logic [63:0]      mem_rdata,
    output logic             halt
);

    localparam int          SHW       = $clog2(WIDTH);
    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) << 3;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } alu_op_e;

    // ------------------------------------------------------------------ ALU
    logic [SHW-1:0] shamt;
    assign shamt = alu_b[SHW-1:0];

    always_comb begin
        // NOTE: assign a default before the case so every path drives the
        // output; otherwise the undecoded selects would infer a latch.
        alu_res = '0;
        case (alu_op_e'(alu_sel))
            OP_ADD:  alu_res = alu_a + alu_b;
            OP_SUB:  alu_res = alu_a - alu_b;
            OP_AND:  alu_res = alu_a & alu_b;
            OP_OR:   alu_res = alu_a | alu_b;
            OP_XOR:  alu_res = alu_a ^ alu_b;
            OP_SLL:  alu_res = alu_a << shamt;
            OP_SRL:  alu_res = alu_a >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(alu_a) >>> shamt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
            default: alu_res = '0;
        endcase
    end

    // -------------------------------------------------------------- control
    logic halt_q;
    logic halt_d;

    always_comb begin
        halt_d = halt_q;
        if (inst == EBREAK) begin
            halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (rst) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    assign halt = halt_q;

    // --------------------------------------------------------------- memory
    logic [63:0]      mem_q [MEM_WORDS];
    logic [63:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic [63:0]      rd_word;
    logic [63:0]      wr_word_d;
    logic             wr_en;

    // The subtraction wraps for addresses below MEM_BASE, hence the explicit
    // lower-bound compare; the upper bound also stops index aliasing.
    assign offset   = mem_addr - MEM_BASE;
    assign in_range = (mem_addr >= MEM_BASE) && (offset < MEM_BYTES);
    assign idx      = offset[IDX_W+2:3];
    assign rd_word  = mem_q[idx];

    assign mem_rdata = in_range ? rd_word : 64'h0;

    // halt_q is the pre-edge value, so an EBREAK and a store on the same edge
    // still commit the store.
    assign wr_en = mem_wen && in_range && !halt_q && !rst;

    always_comb begin
        wr_word_d = rd_word;
        for (int i = 0; i < 8; i++) begin
            if (mem_wmask[i]) begin
                wr_word_d[8*i +: 8] = mem_wdata[8*i +: 8];
            end
        end
    end

    // NOTE: the memory array has no reset branch; contents survive rst and
    // the array maps onto plain RAM rather than thousands of resettable flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx] <= wr_word_d;
        end
    end

endmodule

// File: tb/tb_lemon_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_lemon_exec_unit
//
// Scoreboard bench: each task pushes the expected value when it drives a
// stimulus and pops/compares it when the DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_lemon_exec_unit;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] TOP  = 64'h8000_7FF8;   // last word of 4096
    localparam logic [31:0] EBRK = 32'h0010_0073;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst = NOP;
    logic [63:0] alu_a = '0;
    logic [63:0] alu_b = '0;
    logic [3:0]  alu_sel = '0;
    logic [63:0] alu_res;
    logic [63:0] mem_addr = '0;
    logic [63:0] mem_wdata = '0;
    logic        mem_wen = 1'b0;
    logic [7:0]  mem_wmask = '0;
    logic [63:0] mem_rdata;
    logic        halt;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q [$];

    lemon_exec_unit dut (
        .clk       (clk),
        .rst       (rst),
        .inst      (inst),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_res   (alu_res),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .halt      (halt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    // Stimulus-only helper: one byte-masked write, returns 1 ns after the edge.
    task automatic do_write(input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] mask);
        mem_addr  = addr;
        mem_wdata = data;
        mem_wmask = mask;
        mem_wen   = 1'b1;
        @(posedge clk);
        #1;
        mem_wen   = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] got, e;
        #2 rst = 1'b1;
        alu_sel = 4'd0; alu_a = 64'd1; alu_b = 64'd2;
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd3);
        #1;
        got = {63'd0, halt}; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL reset_halt got %h exp %h", got, e); end
        got = alu_res; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL reset_alu got %h exp %h", got, e); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic [3:0]  sel;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
    } alu_vec_t;

    task automatic test_alu();
        logic [63:0] got, e;
        alu_vec_t v [14] = '{
            '{4'd0,  64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2},
            '{4'd1,  64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF},
            '{4'd2,  64'hF0F0, 64'h0FF0, 64'h00F0},
            '{4'd3,  64'hF0F0, 64'h0FF0, 64'hFFF0},
            '{4'd4,  64'hF0F0, 64'h0FF0, 64'hFF00},
            '{4'd5,  64'd1, 64'h43, 64'd8},
            '{4'd6,  64'h8000_0000_0000_0000, 64'd63, 64'd1},
            '{4'd7,  64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF},
            '{4'd7,  64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000},
            '{4'd8,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1},
            '{4'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0},
            '{4'd8,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0},
            '{4'd12, 64'd5, 64'd3, 64'd0},
            '{4'd15, 64'hFFFF, 64'hFFFF, 64'd0}
        };
        for (int i = 0; i < 14; i++) begin
            alu_sel = v[i].sel; alu_a = v[i].a; alu_b = v[i].b;
            exp_q.push_back(v[i].res);
            #1;
            got = alu_res; e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL alu_op%0d got %h exp %h", v[i].sel, got, e);
            end
        end
    endtask

    task automatic test_mem_write();
        logic [63:0] got, e;
        @(negedge clk);
        do_write(BASE, 64'h1122_3344_5566_7788, 8'hFF);
        mem_addr = BASE; exp_q.push_back(64'h1122_3344_5566_7788); #1;
        got = mem_rdata; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL wr_full got %h exp %h", got, e); end

        do_write(BASE, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        do_write(BASE, 64'h5555_5555_5555_5555, 8'h00);   // no-op mask
        mem_addr = BASE; exp_q.push_back(64'h1122_3344_AAAA_AAAA); #1;
        got = mem_rdata; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL wr_mask got %h exp %h", got, e); end

        // Read-during-write: old word before the edge, new word after it.
        do_write(BASE + 64'd8, 64'h0, 8'hFF);
        mem_addr = BASE + 64'd8; mem_wdata = 64'hCAFE_F00D_1234_5678;
        mem_wmask = 8'hFF; mem_wen = 1'b1;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'hCAFE_F00D_1234_5678);
        #1;
        got = mem_rdata; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL rdw_old got %h exp %h", got, e); end
        @(posedge clk); #1; mem_wen = 1'b0;
        got = mem_rdata; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL rdw_new got %h exp %h", got, e); end
    endtask

    task automatic test_fetch_align();
        logic [63:0] got, e;
        mem_addr = BASE + 64'd4; exp_q.push_back(64'h1122_3344_AAAA_AAAA); #1;
        got = mem_rdata; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL fetch_align got %h exp %h", got, e); end

        mem_addr = 64'h7FFF_FFF8; exp_q.push_back(64'h0); #1;
        got = mem_rdata; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL below_base got %h exp %h", got, e); end

        do_write(TOP, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
        do_write(TOP + 64'd8, 64'h1234_1234_1234_1234, 8'hFF);   // one past top
        exp_q.push_back(64'h0);
        exp_q.push_back(64'hDEAD_BEEF_0BAD_F00D);
        exp_q.push_back(64'h1122_3344_AAAA_AAAA);
        mem_addr = TOP + 64'd8; #1;
        got = mem_rdata; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL past_top_rd got %h exp %h", got, e); end
        mem_addr = TOP; #1;
        got = mem_rdata; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL top_word got %h exp %h", got, e); end
        mem_addr = BASE; #1;
        got = mem_rdata; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL no_alias got %h exp %h", got, e); end
    endtask

    task automatic test_halt();
        logic [63:0] got, e;
        @(negedge clk);
        // EBREAK and a store on the same edge: the store lands.
        inst = EBRK;
        do_write(BASE + 64'h10, 64'h77, 8'hFF);
        inst = NOP;
        exp_q.push_back(64'd1);
        exp_q.push_back(64'h77);
        got = {63'd0, halt}; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL halt_set got %h exp %h", got, e); end
        mem_addr = BASE + 64'h10; #1;
        got = mem_rdata; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL ebreak_wr got %h exp %h", got, e); end

        do_write(BASE + 64'h10, 64'h99, 8'hFF);
        do_write(BASE, 64'h0, 8'hFF);
        exp_q.push_back(64'd1);
        exp_q.push_back(64'h77);
        exp_q.push_back(64'h1122_3344_AAAA_AAAA);
        got = {63'd0, halt}; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL halt_sticky got %h exp %h", got, e); end
        mem_addr = BASE + 64'h10; #1;
        got = mem_rdata; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL halt_blk1 got %h exp %h", got, e); end
        mem_addr = BASE; #1;
        got = mem_rdata; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL halt_blk0 got %h exp %h", got, e); end
    endtask

    task automatic test_async_reset();
        logic [63:0] got, e;
        @(negedge clk);
        #1 rst = 1'b1;
        exp_q.push_back(64'd0);
        exp_q.push_back(64'h77);
        #1;   // still 3 ns before the next rising edge
        got = {63'd0, halt}; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL async_clr got %h exp %h", got, e); end
        mem_addr = BASE + 64'h10; #1;
        got = mem_rdata; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL mem_keep got %h exp %h", got, e); end
        @(negedge clk);
        rst = 1'b0;
        do_write(BASE + 64'h18, 64'h0, 8'hFF);
    endtask

    task automatic test_reset_ebreak();
        logic [63:0] got, e;
        @(negedge clk);
        rst = 1'b1; inst = EBRK;
        do_write(BASE + 64'h18, 64'hFFFF, 8'hFF);   // blocked while in reset
        exp_q.push_back(64'd0);
        exp_q.push_back(64'h0);
        got = {63'd0, halt}; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL rst_ebrk got %h exp %h", got, e); end
        mem_addr = BASE + 64'h18; #1;
        got = mem_rdata; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL rst_wr got %h exp %h", got, e); end
        @(negedge clk);
        rst = 1'b0; inst = NOP;
        @(posedge clk); #1;
        exp_q.push_back(64'd0);
        got = {63'd0, halt}; e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL post_rst got %h exp %h", got, e); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem_write();
        test_fetch_align();
        test_halt();
        test_async_reset();
        test_reset_ebreak();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
